// File: rtl/wave_sample_if.sv
// Valid/ready sample channel between the waveform source and the SPI DAC driver,
// together with the source's control and status signals.
interface wave_sample_if #(
    parameter int PHASE_W = 16,
    parameter int DATA_W  = 12
);
    logic [PHASE_W-1:0] phase_inc;
    logic [1:0]         wave_sel;
    logic               enable;
    logic [DATA_W-1:0]  sample;
    logic               sample_valid;
    logic               sample_ready;
    logic               overrun;
    logic               overrun_clr;

    modport master (
        input  phase_inc, wave_sel, enable, sample_ready, overrun_clr,
        output sample, sample_valid, overrun
    );

    modport slave (
        output phase_inc, wave_sel, enable, sample_ready, overrun_clr,
        input  sample, sample_valid, overrun
    );
endinterface

// File: rtl/wave_sample_source.sv
// Phase-accumulator waveform generator feeding the SPI DAC driver through a
// valid/ready hold register, with a sticky flag for dropped sample ticks.
module wave_sample_source #(
    parameter int PHASE_W  = 16,
    parameter int DATA_W   = 12,
    parameter int RATE_DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    wave_sample_if.master bus
);
    localparam int CNT_W = $clog2(RATE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE_DIV - 1);

    logic [CNT_W-1:0]   rate_cnt;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] next_phase;
    logic [DATA_W-1:0]  sample_q;
    logic [DATA_W-1:0]  next_sample;
    logic               valid_q;
    logic               overrun_q;
    logic               tick;
    logic               slot_free;

    function automatic logic [DATA_W-1:0] wave_of(input logic [PHASE_W-1:0] p,
                                                  input logic [1:0]         sel);
        logic [DATA_W-1:0] w;
        case (sel)
            2'd0:    w = p[PHASE_W-1 -: DATA_W];
            2'd1:    w = p[PHASE_W-1] ? ~p[PHASE_W-2 -: DATA_W] : p[PHASE_W-2 -: DATA_W];
            2'd2:    w = {DATA_W{p[PHASE_W-1]}};
            default: w = DATA_W'(1) << (DATA_W - 1);
        endcase
        return w;
    endfunction

    // A tick can only load a new sample if the old one is gone or leaving this cycle.
    assign tick        = bus.enable && (rate_cnt == CNT_LAST);
    assign slot_free   = !valid_q || bus.sample_ready;
    assign next_phase  = phase + bus.phase_inc;
    assign next_sample = wave_of(next_phase, bus.wave_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            rate_cnt  <= '0;
            phase     <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.enable) begin
                rate_cnt <= (rate_cnt == CNT_LAST) ? '0 : rate_cnt + CNT_W'(1);
            end

            if (tick && slot_free) begin
                phase    <= next_phase;
                sample_q <= next_sample;
                valid_q  <= 1'b1;
            end else if (!tick && valid_q && bus.sample_ready) begin
                valid_q <= 1'b0;
            end

            // Set has priority over clear so a drop in the clear cycle is not lost.
            if (tick && !slot_free) begin
                overrun_q <= 1'b1;
            end else if (bus.overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_wave_sample_source.sv
// Directed bench for wave_sample_source: a table of free-running samples plus
// hand-written backpressure, accept-on-tick, enable and reset sequences.
module tb_wave_sample_source;
    typedef struct {
        logic [15:0] inc;
        logic [1:0]  sel;
        logic [11:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   cyc;
    vec_t vecs[$];

    wave_sample_if #(.PHASE_W(16), .DATA_W(12)) bus ();

    wave_sample_source #(.PHASE_W(16), .DATA_W(12), .RATE_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Step to the next negedge, then keep stepping until sample_valid is seen.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.sample_valid && cycles < 50);
        if (!bus.sample_valid) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL wait_valid: timeout after %0d cycles, expected valid=1", cycles);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.phase_inc    = 16'h1000;
        bus.wave_sel     = 2'd0;
        bus.enable       = 1'b1;
        bus.sample_ready = 1'b1;
        bus.overrun_clr  = 1'b0;

        // Free-running vectors from phase 0, one sample per tick, ready held high.
        for (int i = 1; i <= 16; i++) vecs.push_back('{inc: 16'h1000, sel: 2'd0, exp: 12'((i * 16'h100) & 16'hFFF)});
        vecs.push_back('{inc: 16'h4000, sel: 2'd1, exp: 12'h800});
        vecs.push_back('{inc: 16'h4000, sel: 2'd1, exp: 12'hFFF});
        vecs.push_back('{inc: 16'h4000, sel: 2'd1, exp: 12'h7FF});
        vecs.push_back('{inc: 16'h4000, sel: 2'd1, exp: 12'h000});
        vecs.push_back('{inc: 16'h8000, sel: 2'd2, exp: 12'hFFF});
        vecs.push_back('{inc: 16'h8000, sel: 2'd2, exp: 12'h000});
        vecs.push_back('{inc: 16'h8000, sel: 2'd2, exp: 12'hFFF});
        vecs.push_back('{inc: 16'h8000, sel: 2'd2, exp: 12'h000});
        vecs.push_back('{inc: 16'h1234, sel: 2'd3, exp: 12'h800});
        vecs.push_back('{inc: 16'h1234, sel: 2'd3, exp: 12'h800});
        vecs.push_back('{inc: 16'h1234, sel: 2'd3, exp: 12'h800});
        vecs.push_back('{inc: 16'h0000, sel: 2'd0, exp: 12'h369});
        vecs.push_back('{inc: 16'h0000, sel: 2'd0, exp: 12'h369});
        vecs.push_back('{inc: 16'h0964, sel: 2'd0, exp: 12'h400});
        vecs.push_back('{inc: 16'h2000, sel: 2'd1, exp: 12'hC00});
        vecs.push_back('{inc: 16'h2000, sel: 2'd1, exp: 12'hFFF});

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_valid", 16'(bus.sample_valid), 16'h0);
        check("reset_sample", 16'(bus.sample), 16'h0);
        check("reset_overrun", 16'(bus.overrun), 16'h0);

        do_reset();
        foreach (vecs[i]) begin
            bus.phase_inc = vecs[i].inc;
            bus.wave_sel  = vecs[i].sel;
            wait_valid(cyc);
            check($sformatf("vec%0d_sample", i), 16'(bus.sample), 16'(vecs[i].exp));
            check($sformatf("vec%0d_period", i), 16'(cyc), (i == 0) ? 16'd4 : 16'd4);
        end
        check("table_overrun", 16'(bus.overrun), 16'h0);

        // Backpressure: first sample held, second tick dropped, phase frozen.
        bus.phase_inc = 16'h1000;
        bus.wave_sel  = 2'd0;
        bus.sample_ready = 1'b0;
        do_reset();
        wait_valid(cyc);
        check("bp_first", 16'(bus.sample), 16'h100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_sample", 16'(bus.sample), 16'h100);
            check("bp_hold_valid", 16'(bus.sample_valid), 16'h1);
        end
        check("bp_overrun_set", 16'(bus.overrun), 16'h1);
        bus.sample_ready = 1'b1;
        wait_valid(cyc);
        check("bp_next_sample", 16'(bus.sample), 16'h200);
        check("bp_overrun_sticky", 16'(bus.overrun), 16'h1);
        bus.overrun_clr = 1'b1;
        @(negedge clk);
        bus.overrun_clr = 1'b0;
        check("bp_overrun_clr", 16'(bus.overrun), 16'h0);

        // Accept exactly on the tick edge: no bubble, no overrun.
        bus.sample_ready = 1'b0;
        do_reset();
        wait_valid(cyc);
        check("aot_first", 16'(bus.sample), 16'h100);
        repeat (3) @(negedge clk);
        check("aot_pre_valid", 16'(bus.sample_valid), 16'h1);
        bus.sample_ready = 1'b1;
        @(negedge clk);
        bus.sample_ready = 1'b0;
        check("aot_valid", 16'(bus.sample_valid), 16'h1);
        check("aot_sample", 16'(bus.sample), 16'h200);
        check("aot_overrun", 16'(bus.overrun), 16'h0);

        // Enable low freezes the rate counter mid-count with the sample pending.
        do_reset();
        wait_valid(cyc);
        repeat (2) @(negedge clk);
        bus.enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("en_hold_valid", 16'(bus.sample_valid), 16'h1);
            check("en_hold_sample", 16'(bus.sample), 16'h100);
            check("en_hold_overrun", 16'(bus.overrun), 16'h0);
        end
        bus.enable = 1'b1;
        @(negedge clk);
        check("en_resume_1", 16'(bus.overrun), 16'h0);
        @(negedge clk);
        check("en_resume_2", 16'(bus.overrun), 16'h1);

        // Reset while a sample is pending and overrun is set.
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 16'(bus.sample_valid), 16'h0);
        check("mid_rst_sample", 16'(bus.sample), 16'h0);
        check("mid_rst_overrun", 16'(bus.overrun), 16'h0);
        rst = 1'b0;
        bus.sample_ready = 1'b1;
        wait_valid(cyc);
        check("mid_rst_latency", 16'(cyc), 16'd4);
        check("mid_rst_first", 16'(bus.sample), 16'h100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
